// File: rtl/fb_scanout_read_engine_pkg.sv
// ----------------------------------------------------------------------------
// fb_scanout_read_engine_pkg
// Shared definitions for the framebuffer scanout read engine: arbiter
// operation codes, FSM state encodings and a small address helper.
// ----------------------------------------------------------------------------
package fb_scanout_read_engine_pkg;

  localparam logic ARB_OP_READ  = 1'b0;
  localparam logic ARB_OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } scan_state_e;

  // Next word address; wraps from 16'hFFFF back to 16'h0000.
  function automatic logic [15:0] addr_incr(input logic [15:0] addr);
    return addr + 16'd1;
  endfunction

endpackage

// File: rtl/fb_scanout_read_engine_fifo.sv
// ----------------------------------------------------------------------------
// fb_scanout_read_engine_fifo
// Return-data FIFO. Pushed data is visible at the head on the next cycle.
// Push and pop in the same cycle are allowed when full (and when empty the
// pop is simply ignored).
// Ports:
//   clk        in  clock
//   rst_       in  synchronous active-high reset
//   push       in  write request
//   push_data  in  DATA_WIDTH write data
//   pop        in  read request (ignored when empty)
//   pop_data   out head entry
//   empty      out no entries held
//   count      out number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module fb_scanout_read_engine_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LOG2DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [LOG2DEPTH:0]    count
);

  localparam logic [LOG2DEPTH:0] FULL_CNT = (LOG2DEPTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [LOG2DEPTH-1:0]  wr_ptr_r;
  logic [LOG2DEPTH-1:0]  rd_ptr_r;
  logic [LOG2DEPTH:0]    count_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // A write at full is only taken when the head is leaving in the same cycle.
  assign wr_en_s  = push && ((count_r != FULL_CNT) || (pop && (count_r != '0)));
  assign rd_en_s  = pop && (count_r != '0);
  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = (count_r == '0);
  assign count    = count_r;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(LOG2DEPTH-1){1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{(LOG2DEPTH-1){1'b0}}, 1'b1};
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + {{LOG2DEPTH{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{LOG2DEPTH{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout_read_engine.sv
// ----------------------------------------------------------------------------
// fb_scanout_read_engine
// Reads one framebuffer frame per start pulse through the arbiter client
// interface, gathers the broadcast read returns in a local FIFO and streams
// them to the pixel consumer with an rts/rtr handshake.
//
// Optional feature macro: SCANOUT_UNDERRUN_EN
//   defined     : sticky underrun flag (consumer ready, FIFO empty, busy)
//   not defined : underrun tied low
//
// Ports:
//   clk, rst_                 clock, synchronous active-high reset
//   start / busy / frame_done frame control and status
//   arb_out_*  / arb_in_rtr   read request interface (always op = read)
//   arb_bcast_in_data/_xfc    read return data and per-client valid
//   pix_out_data/_rts, pix_in_rtr  pixel stream to consumer
//   underrun                  sticky underrun indication
// ----------------------------------------------------------------------------
module fb_scanout_read_engine
  import fb_scanout_read_engine_pkg::*;
#(
  parameter logic [15:0] FB_BASE         = 16'h0000,
  parameter logic [15:0] WORDS_PER_FRAME = 16'd9600,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          LOG2DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        arb_out_rts,
  input  logic        arb_in_rtr,
  output logic [15:0] arb_out_addr,
  output logic        arb_out_op,
  output logic [3:0]  arb_out_wben,
  output logic [31:0] arb_out_data,
  input  logic [31:0] arb_bcast_in_data,
  input  logic        arb_bcast_in_xfc,
  output logic [31:0] pix_out_data,
  output logic        pix_out_rts,
  input  logic        pix_in_rtr,
  output logic        underrun
);

  localparam logic [LOG2DEPTH+1:0] CREDIT_LIMIT = (LOG2DEPTH+2)'(FIFO_DEPTH);

  scan_state_e          state_r;
  scan_state_e          state_nxt_s;
  logic [15:0]          addr_r;
  logic [15:0]          issued_r;
  logic [LOG2DEPTH:0]   outstanding_r;
  logic [LOG2DEPTH:0]   fifo_count_s;
  logic                 fifo_empty_s;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 credit_s;
  logic                 accept_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 last_s;
  logic                 start_acc_s;

  // Requests in flight plus queued words never exceed the FIFO size, so
  // every return has a slot waiting for it.
  assign credit_s    = ({1'b0, outstanding_r} + {1'b0, fifo_count_s}) < CREDIT_LIMIT;
  assign arb_out_rts = (state_r == S_ISSUE) && credit_s;
  assign accept_s    = arb_out_rts && arb_in_rtr;
  assign push_s      = arb_bcast_in_xfc && (outstanding_r != '0);
  assign pop_s       = pix_out_rts && pix_in_rtr;
  assign last_s      = (issued_r == (WORDS_PER_FRAME - 16'd1));
  assign start_acc_s = start && (state_r == S_IDLE);

  assign arb_out_addr = addr_r;
  assign arb_out_op   = ARB_OP_READ;
  assign arb_out_wben = 4'b0000;
  assign arb_out_data = 32'd0;
  assign busy         = busy_r;
  assign frame_done   = frame_done_r;
  assign pix_out_rts  = !fifo_empty_s;

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (accept_s && last_s) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outstanding_r == '0) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register plus registered busy / frame_done status.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_r      <= S_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy_r       <= (state_nxt_s != S_IDLE);
      frame_done_r <= (state_r == S_DRAIN) && (state_nxt_s == S_IDLE);
    end
  end

  // Request address, issued count and in-flight request count.
  always_ff @(posedge clk) begin
    if (rst_) begin
      addr_r        <= FB_BASE;
      issued_r      <= 16'd0;
      outstanding_r <= '0;
    end else begin
      if (start_acc_s) begin
        addr_r   <= FB_BASE;
        issued_r <= 16'd0;
      end else if (accept_s) begin
        addr_r   <= addr_incr(addr_r);
        issued_r <= issued_r + 16'd1;
      end else begin
        addr_r   <= addr_r;
        issued_r <= issued_r;
      end
      case ({accept_s, push_s})
        2'b10:   outstanding_r <= outstanding_r + {{LOG2DEPTH{1'b0}}, 1'b1};
        2'b01:   outstanding_r <= outstanding_r - {{LOG2DEPTH{1'b0}}, 1'b1};
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  fb_scanout_read_engine_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (FIFO_DEPTH),
    .LOG2DEPTH  (LOG2DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_      (rst_),
    .push      (push_s),
    .push_data (arb_bcast_in_data),
    .pop       (pop_s),
    .pop_data  (pix_out_data),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

`ifdef SCANOUT_UNDERRUN_EN
  logic underrun_r;

  // Sticky underrun: consumer was ready during a frame but nothing was queued.
  always_ff @(posedge clk) begin
    if (rst_) begin
      underrun_r <= 1'b0;
    end else if (start_acc_s) begin
      underrun_r <= 1'b0;
    end else if (busy_r && pix_in_rtr && !pix_out_rts) begin
      underrun_r <= 1'b1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign underrun = underrun_r;
`else
  assign underrun = 1'b0;
`endif

endmodule
